// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the execute-stage branch resolution bus, the 2-bit
// predictor state, and the branch target buffer entry layout.
package pipeline_pkg;

    // Default number of BTB entries when the parent does not override it.
    localparam int BTB_DEFAULT_ENTRIES = 16;

    // Widest tag any legal BTB size can need (32 - 2 byte-offset bits).
    // Tags are zero-extended into this field so the entry type stays fixed.
    localparam int BTB_TAG_W = 30;

    // Two-bit saturating predictor: upper bit set means "predict taken".
    typedef enum logic [1:0] {
        NN = 2'b00,
        NT = 2'b01,
        TN = 2'b10,
        TT = 2'b11
    } predictor_t;

    // Resolved branch as reported by the execute stage.
    typedef struct packed {
        logic        br_valid;
        logic        br_update_en;
        logic [31:0] br_update_pc;
        logic [31:0] br_pc_plus4;
        logic        br_taken;
        logic        br_already_predicted;
        logic [31:0] br_target;
    } branch_t;

    // One BTB line.
    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        predictor_t           state;
    } btb_entry_t;

    // True when a predictor state predicts taken.
    function automatic logic predicts_taken(input predictor_t state);
        return state[1];
    endfunction

endpackage

// File: rtl/prd_sat_counter.sv
// Next-state logic of a 2-bit saturating branch predictor. Purely
// combinational so it can be shared by the BTB and any future BHT.
module prd_sat_counter
    import pipeline_pkg::*;
(
    input  predictor_t state,
    input  logic       taken,
    output predictor_t next_state
);

    // Step toward TT on taken and toward NN on not-taken, saturating at both ends.
    always_comb begin
        next_state = state;
        case (state)
            NN:      next_state = taken ? NT : NN;
            NT:      next_state = taken ? TN : NN;
            TN:      next_state = taken ? TT : NT;
            TT:      next_state = taken ? TT : TN;
            default: next_state = NN;
        endcase
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with a 2-bit predictor per entry.
// Fetch lookup is combinational; resolved branches from execute update the
// table at the clock edge and raise a same-cycle mispredict/redirect.
module branch_predictor_btb
    import pipeline_pkg::*;
#(
    parameter  int BTB_ENTRIES = BTB_DEFAULT_ENTRIES,
    localparam int IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_fetch_pc,
    input  logic        i_fetch_valid,
    output logic        o_prd_taken,
    output logic [31:0] o_prd_target,
    input  branch_t     i_branch,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
);

    btb_entry_t btb_mem [BTB_ENTRIES];

    logic [IDX_W-1:0]     fetch_idx;
    logic [BTB_TAG_W-1:0] fetch_tag;
    btb_entry_t           fetch_entry;
    logic                 fetch_hit;

    logic [IDX_W-1:0]     upd_idx;
    logic [BTB_TAG_W-1:0] upd_tag;
    btb_entry_t           upd_entry;
    logic                 upd;
    logic                 upd_hit;
    logic                 target_differs;
    predictor_t           upd_next_state;

    logic [31:0] br_count_q;
    logic [31:0] mispred_count_q;

    // Byte-offset bits of both PCs carry no information for the table.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, i_fetch_pc[1:0], i_branch.br_update_pc[1:0]};

    // Split the fetch and update PCs into index and zero-extended tag.
    always_comb begin
        fetch_idx = i_fetch_pc[IDX_W+1:2];
        fetch_tag = BTB_TAG_W'(i_fetch_pc[31:IDX_W+2]);
        upd_idx   = i_branch.br_update_pc[IDX_W+1:2];
        upd_tag   = BTB_TAG_W'(i_branch.br_update_pc[31:IDX_W+2]);
    end

    assign fetch_entry = btb_mem[fetch_idx];
    assign upd_entry   = btb_mem[upd_idx];

    // Fetch-side prediction from the registered table contents; no bypass of
    // an update landing in the same cycle.
    always_comb begin
        fetch_hit    = i_fetch_valid & fetch_entry.valid & (fetch_entry.tag == fetch_tag);
        o_prd_taken  = fetch_hit & predicts_taken(fetch_entry.state);
        o_prd_target = o_prd_taken ? fetch_entry.target : 32'h0;
    end

    // Resolve the branch against the table: wrong direction, or a taken
    // branch whose stored target no longer matches, needs a flush.
    always_comb begin
        upd            = i_branch.br_update_en & i_branch.br_valid;
        upd_hit        = upd_entry.valid & (upd_entry.tag == upd_tag);
        target_differs = upd_entry.target != i_branch.br_target;
        o_mispredict   = upd & ((i_branch.br_taken != i_branch.br_already_predicted) |
                                (i_branch.br_taken & i_branch.br_already_predicted &
                                 upd_hit & target_differs));
        o_redirect_pc  = 32'h0;
        if (o_mispredict) begin
            o_redirect_pc = i_branch.br_taken ? i_branch.br_target : i_branch.br_pc_plus4;
        end
    end

    prd_sat_counter u_sat_counter (
        .state      (upd_entry.state),
        .taken      (i_branch.br_taken),
        .next_state (upd_next_state)
    );

    // Table maintenance: train on hits, allocate only on taken misses so a
    // not-taken alias never evicts a useful entry. Reset clears everything.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_mem[i] <= '{valid: 1'b0, tag: '0, target: 32'h0, state: NN};
            end
        end else if (upd) begin
            if (upd_hit) begin
                btb_mem[upd_idx].state <= upd_next_state;
                if (i_branch.br_taken) begin
                    btb_mem[upd_idx].target <= i_branch.br_target;
                end
            end else if (i_branch.br_taken) begin
                btb_mem[upd_idx] <= '{valid:  1'b1,
                                      tag:    upd_tag,
                                      target: i_branch.br_target,
                                      state:  TN};
            end
        end
    end

    // Branch and mispredict statistics, free-running modulo 2^32.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            br_count_q      <= 32'h0;
            mispred_count_q <= 32'h0;
        end else if (upd) begin
            br_count_q <= br_count_q + 32'd1;
            if (o_mispredict) begin
                mispred_count_q <= mispred_count_q + 32'd1;
            end
        end
    end

    assign o_br_count      = br_count_q;
    assign o_mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios followed
// by randomized traffic, all compared against a behavioural table model.
module tb_branch_predictor_btb;
    import pipeline_pkg::*;

    localparam int ENTRIES = 16;
    localparam int IW      = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_fetch_pc;
    logic        i_fetch_valid;
    logic        o_prd_taken;
    logic [31:0] o_prd_target;
    branch_t     i_branch;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_count;
    logic [31:0] o_mispred_count;

    branch_predictor_btb #(.BTB_ENTRIES(ENTRIES)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_fetch_pc      (i_fetch_pc),
        .i_fetch_valid   (i_fetch_valid),
        .o_prd_taken     (o_prd_taken),
        .o_prd_target    (o_prd_target),
        .i_branch        (i_branch),
        .o_mispredict    (o_mispredict),
        .o_redirect_pc   (o_redirect_pc),
        .o_br_count      (o_br_count),
        .o_mispred_count (o_mispred_count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 i_clk = ~i_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: one slot per index, tag kept as the full upper PC.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_state  [ENTRIES];
    logic [31:0] m_br_count;
    logic [31:0] m_mis_count;

    logic        obs_taken;
    logic [31:0] obs_target;
    logic        obs_mis;
    logic [31:0] obs_redir;

    // Compare one observed value with its expected value and report mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc >> (IW + 2));
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit model_pred(input logic [31:0] pc);
        return model_hit(pc) && (m_state[idx_of(pc)] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 32'h0;
            m_state[i]  = 0;
        end
        m_br_count  = 32'h0;
        m_mis_count = 32'h0;
    endtask

    // Drive one cycle of fetch and branch inputs, check every output against
    // the model mid-cycle, then advance the model and the clock.
    task automatic applyStimulus(input logic [31:0] fpc, input logic fv,
                                 input logic bval, input logic ben,
                                 input logic [31:0] bpc, input logic taken,
                                 input logic [31:0] target, input logic already);
        bit          exp_taken, upd, b_hit, exp_mis;
        logic [31:0] exp_tgt, exp_redir;
        int          bi;
        i_fetch_pc                    = fpc;
        i_fetch_valid                 = fv;
        i_branch.br_valid             = bval;
        i_branch.br_update_en         = ben;
        i_branch.br_update_pc         = bpc;
        i_branch.br_pc_plus4          = bpc + 32'd4;
        i_branch.br_taken             = taken;
        i_branch.br_target            = target;
        i_branch.br_already_predicted = already;
        #4;
        exp_taken = fv && model_pred(fpc);
        exp_tgt   = exp_taken ? m_target[idx_of(fpc)] : 32'h0;
        upd       = bval && ben;
        bi        = idx_of(bpc);
        b_hit     = model_hit(bpc);
        exp_mis   = upd && ((taken != already) ||
                            (taken && already && b_hit && m_target[bi] != target));
        exp_redir = exp_mis ? (taken ? target : bpc + 32'd4) : 32'h0;

        obs_taken  = o_prd_taken;
        obs_target = o_prd_target;
        obs_mis    = o_mispredict;
        obs_redir  = o_redirect_pc;
        checkOutput("prd_taken",     {31'h0, o_prd_taken},  {31'h0, exp_taken});
        checkOutput("prd_target",    o_prd_target,          exp_tgt);
        checkOutput("mispredict",    {31'h0, o_mispredict}, {31'h0, exp_mis});
        checkOutput("redirect_pc",   o_redirect_pc,         exp_redir);
        checkOutput("br_count",      o_br_count,            m_br_count);
        checkOutput("mispred_count", o_mispred_count,       m_mis_count);

        if (upd) begin
            m_br_count = m_br_count + 32'd1;
            if (exp_mis) m_mis_count = m_mis_count + 32'd1;
            if (b_hit) begin
                if (taken) begin
                    m_state[bi]  = (m_state[bi] < 3) ? m_state[bi] + 1 : 3;
                    m_target[bi] = target;
                end else begin
                    m_state[bi] = (m_state[bi] > 0) ? m_state[bi] - 1 : 0;
                end
            end else if (taken) begin
                m_valid[bi]  = 1'b1;
                m_tag[bi]    = tag_of(bpc);
                m_target[bi] = target;
                m_state[bi]  = 2;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] fpc);
        applyStimulus(fpc, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic update(input logic [31:0] fpc, input logic [31:0] bpc,
                          input logic taken, input logic [31:0] target,
                          input logic already);
        applyStimulus(fpc, 1'b1, 1'b1, 1'b1, bpc, taken, target, already);
    endtask

    initial begin
        logic [31:0] rpc, bpc, tgt;
        logic        tk, al;

        i_rst         = 1'b1;
        i_fetch_pc    = 32'h100;
        i_fetch_valid = 1'b1;
        i_branch      = '0;
        model_reset();
        #2;
        checkOutput("rst_prd_taken", {31'h0, o_prd_taken}, 32'h0);
        checkOutput("rst_br_count",  o_br_count,           32'h0);
        #10;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Lookup after reset misses.
        lookup(32'h100);

        // First taken branch allocates at TN and is a mispredict.
        update(32'h100, 32'h40, 1'b1, 32'h80, 1'b0);
        checkOutput("t2_mis",   {31'h0, obs_mis}, 32'h1);
        checkOutput("t2_redir", obs_redir,        32'h80);
        lookup(32'h40);
        checkOutput("t2_taken",  {31'h0, obs_taken}, 32'h1);
        checkOutput("t2_target", obs_target,         32'h80);
        checkOutput("t2_miscnt", o_mispred_count,    32'h1);

        // Two not-taken resolutions walk the counter down to NN.
        update(32'h100, 32'h40, 1'b0, 32'h80, 1'b1);
        checkOutput("t3a_mis",   {31'h0, obs_mis}, 32'h1);
        checkOutput("t3a_redir", obs_redir,        32'h44);
        lookup(32'h40);
        checkOutput("t3a_taken", {31'h0, obs_taken}, 32'h0);
        update(32'h100, 32'h40, 1'b0, 32'h80, 1'b0);
        checkOutput("t3b_mis", {31'h0, obs_mis}, 32'h0);
        lookup(32'h100);
        checkOutput("t3b_brcnt", o_br_count, 32'd3);

        // Taken alias replaces; not-taken alias leaves the resident entry alone.
        update(32'h100, 32'h80, 1'b1, 32'h1234, 1'b0);
        lookup(32'h40);
        checkOutput("t4_old_miss", {31'h0, obs_taken}, 32'h0);
        lookup(32'h80);
        checkOutput("t4_new_hit", obs_target, 32'h1234);
        update(32'h100, 32'h140, 1'b0, 32'h0, 1'b0);
        lookup(32'h80);
        checkOutput("t4_retained", obs_target, 32'h1234);

        // Same-cycle lookup sees pre-update contents.
        update(32'h200, 32'h200, 1'b1, 32'h600, 1'b0);
        checkOutput("t5_same_cycle", {31'h0, obs_taken}, 32'h0);
        lookup(32'h200);
        checkOutput("t5_next_cycle", {31'h0, obs_taken}, 32'h1);

        // Randomized traffic over a small PC space to force aliasing.
        for (int n = 0; n < 400; n++) begin
            rpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            bpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) rpc = bpc;
            tk  = 1'($urandom_range(0, 1));
            tgt = $urandom_range(0, 1) ? 32'h1000 + (bpc & 32'hFC) : $urandom & 32'hFFFF_FFFC;
            al  = $urandom_range(0, 1) ? model_pred(bpc) : 1'($urandom_range(0, 1));
            applyStimulus(rpc, 1'($urandom_range(0, 7) != 0),
                          1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
                          bpc, tk, tgt, al);
        end

        // Asynchronous reset mid-cycle while an update is being presented.
        update(32'h100, 32'h300, 1'b1, 32'h900, 1'b0);
        i_fetch_pc                    = 32'h300;
        i_fetch_valid                 = 1'b1;
        i_branch.br_valid             = 1'b1;
        i_branch.br_update_en         = 1'b1;
        i_branch.br_update_pc         = 32'h340;
        i_branch.br_pc_plus4          = 32'h344;
        i_branch.br_taken             = 1'b1;
        i_branch.br_target            = 32'hA00;
        i_branch.br_already_predicted = 1'b0;
        #2;
        checkOutput("t6_pre_taken", {31'h0, o_prd_taken}, 32'h1);
        i_rst = 1'b1;
        #1;
        checkOutput("t6_taken",  {31'h0, o_prd_taken}, 32'h0);
        checkOutput("t6_target", o_prd_target,         32'h0);
        checkOutput("t6_brcnt",  o_br_count,           32'h0);
        checkOutput("t6_miscnt", o_mispred_count,      32'h0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        lookup(32'h340);
        checkOutput("t6_no_write", {31'h0, obs_taken}, 32'h0);
        lookup(32'h300);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Direct-mapped branch target buffer with a 2-bit saturating predictor per entry. It is the consumer of the execute-stage branch_t resolution bus. It is also the producer of the prd_taken/target prediction that fetch packs into fetch_t.
- Fetch-side lookup is combinational.
- Table update happens at the clock edge from resolved branches.
- Same-cycle mispredict/redirect is generated for the pipeline flush logic.
- Branch and mispredict statistics are kept.

Parameters:
BTB_ENTRIES, 16, number of entries; must be a power of 2, minimum 2.
IDX_W, $clog2(BTB_ENTRIES), index width (derived; must not be overridden).

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  reset, asynchronous, active-high.
i_fetch_pc  input  32  PC being fetched.
i_fetch_valid  input  1  lookup qualifier.
o_prd_taken  output  1  predicted taken for i_fetch_pc.
o_prd_target  output  32  predicted target; 0 when o_prd_taken=0.
i_branch  input  branch_t  resolved-branch bus from execute.
o_mispredict  output  1  flush request, same cycle as i_branch.
o_redirect_pc  output  32  correct next PC when o_mispredict=1, else 0.
o_br_count  output  32  resolved valid branches.
o_mispred_count  output  32  mispredicts.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is asynchronous, active-high.
- PC fields: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] is ignored.
- Entry contents: valid, tag, target[31:0], state (predictor_t).
- Reset (async, immediate): all valid=0, state=NN, target=0, both counters=0. Result: o_prd_taken=0, o_prd_target=0. o_mispredict=0 unless i_branch is active.
- Lookup (combinational):
  - hit = i_fetch_valid & entry.valid & tag match.
  - o_prd_taken = hit & state[1] (TN or TT).
  - o_prd_target = o_prd_taken ? entry.target : 0.
- Update qualifier: upd = i_branch.br_update_en & i_branch.br_valid. Nothing in the block changes when upd=0.
- Mispredict (combinational, gated by upd):
  - taken != br_already_predicted, or
  - taken & br_already_predicted & (hit at br_update_pc) & stored target != br_target.
  - o_redirect_pc = br_taken ? br_target : br_pc_plus4.
- Table write at the clock edge when upd:
  - Hit, taken: state steps up (NN->NT->TN->TT, saturating at TT); target <= br_target.
  - Hit, not taken: state steps down (TT->TN->NT->NN, saturating at NN); target is unchanged.
  - Miss, taken: allocate or replace the entry: valid=1, tag written, target written, state=TN.
  - Miss, not taken: no write.
- Counters: o_br_count += 1 per upd cycle; o_mispred_count += 1 per mispredict cycle. Both are 32-bit, wrap modulo 2^32, and are registered.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. The new value is visible from the next cycle. There is no bypass.
- Aliasing: a different tag at the same index replaces the entry only on a taken miss. A not-taken miss never evicts.
- Reset asserted mid-update: reset wins; the table and counters clear regardless of i_branch.
- Latency: prediction 0 cycles; table update visible 1 cycle after the update edge.

Decomposition:
- pipeline_pkg: reuse branch_t and predictor_t. Add btb_entry_t {valid, tag, target, predictor_t state}. Add localparam BTB_DEFAULT_ENTRIES=16.
- Sub-module prd_sat_counter: combinational next-state of predictor_t given taken. It is shared with any future BHT.

Test Plan:
1. Reset, then lookup pc=0x100 valid -> o_prd_taken=0, o_prd_target=0, counters=0.
2. Update pc=0x40, taken, target=0x80, already_predicted=0 -> o_mispredict=1, o_redirect_pc=0x80, o_mispred_count=1 next cycle. Next-cycle lookup 0x40 -> taken=1, target=0x80 (state TN).
3. Two not-taken updates at 0x40:
   - First update, already_predicted=1: mispredict=1, redirect=0x44, state NT; lookup afterwards -> not taken.
   - Second update, already_predicted=0: mispredict=0, state NN; o_br_count=3.
4. Taken update at 0x80 (index 0, tag 2) with 0x40 (index 0, tag 1) resident -> 0x40 lookup now misses; 0x80 hits with its target. Not-taken update at 0x140 (index 0, tag 5) -> entry for 0x80 is retained.
5. Lookup and taken update of 0x200 in the same cycle -> o_prd_taken=0 that cycle; =1 the following cycle.
6. Assert i_rst between edges with entries valid and counters non-zero -> prediction and counters read 0 immediately, before the next clock edge.
